multicycle_controller: RTL
==========================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, reset, asynchronous, active-low.
REQ-002 SHALL have inputs: opcode 7 instruction[6:0]; funct3 3 instruction[14:12]; funct7b5 1 instruction[30]; zero_flag 1, ALU result zero; sign_flag 1, ALU result negative; mem_ready 1, memory access complete this cycle.
REQ-003 SHALL have strobe outputs, 1 bit each: pc_write, ir_write, mem_write, reg_write, adr_src (0 PC, 1 result).
REQ-004 SHALL have select outputs: alu_src_a 2 (00 PC, 01 old_pc, 10 rd1); alu_src_b 2 (00 rd2, 01 imm, 10 const 4); result_src 2 (00 alu_out, 01 read data, 10 alu_result); imm_src 2 (00 I, 01 S, 10 B, 11 J); alu_control 3.
REQ-005 SHALL have status outputs: state 4, current state for debug; illegal_instr 1, one-cycle pulse.

Function
REQ-006 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-007 FETCH: adr_src=0, a=00, b=10, aluop=add, result_src=10; hold while mem_ready=0; when mem_ready=1, pulse ir_write and pc_write for that cycle and go to DECODE.
REQ-008 DECODE: a=01, b=01, aluop=add, so branch/jump target is computed; next state by opcode: 0000011/0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BRANCH, 1101111 -> JAL.
REQ-009 Any other opcode in DECODE SHALL pulse illegal_instr, go to FETCH, and assert no write strobe.
REQ-010 MEMADR: a=10, b=01, aluop=add; next state MEMREAD for load, MEMWRITE for store.
REQ-011 MEMREAD: adr_src=1, result_src=00; hold until mem_ready=1, then go to MEMWB.
REQ-012 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-013 MEMWRITE: adr_src=1, result_src=00, mem_write=1 every cycle in the state; go to FETCH in the cycle mem_ready=1.
REQ-014 EXECR: a=10, b=00, aluop=funct. EXECI: a=10, b=01, aluop=funct. Both go next to ALUWB.
REQ-015 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-016 JAL: a=01, b=10, aluop=add, result_src=00, pc_write=1; next state ALUWB.
REQ-017 BRANCH: a=10, b=00, aluop=sub, result_src=00; pc_write=taken; next state FETCH.
REQ-018 BRANCH taken rule: beq (funct3=000) taken when zero_flag=1.
REQ-019 imm_src SHALL be combinational from opcode in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
REQ-020 alu_control SHALL be decoded as follows: add=000, sub=001, and=010, or=011, slt=101.
REQ-021 For aluop=funct, funct3 SHALL select the ALU operation: 000 is sub if opcode[5] and funct7b5, else add; 010 is slt; 110 is or; 111 is and; other values give add.
REQ-022 Latency with zero-wait memory: R/I/JAL 4 cycles, load 5 cycles, store 4 cycles, branch 3 cycles; each mem_ready=0 cycle adds one.
REQ-023 Inputs other than mem_ready SHALL be sampled only in DECODE, BRANCH and FETCH transition cycles; they are don't-care elsewhere.

Reset
REQ-024 While rst_n=0, state SHALL be FETCH and pc_write, ir_write, mem_write, reg_write, illegal_instr SHALL be 0.
REQ-025 Reset assertion mid-instruction SHALL abort immediately with no strobe.
REQ-026 After rst_n deasserts, the first ir_write SHALL not occur before the first rising clk edge.

Configuration
REQ-027 When macro MC_CTRL_BRANCH_EXT_EN is defined, BRANCH SHALL also decode bne (001, taken when !zero_flag), blt (100, taken when sign_flag) and bge (101, taken when !sign_flag).
REQ-028 When MC_CTRL_BRANCH_EXT_EN is undefined, only beq is decoded and every other funct3 is not taken.
REQ-029 Other funct3 values SHALL be not taken in both builds.

Structure
REQ-030 A shared package SHALL hold the state enum (4-bit, FETCH=0 through JAL=10), opcode constants, alu_control codes, and aluop codes (add=00, sub=01, funct=10).
REQ-031 One sub-module mc_alu_decoder SHALL map aluop, opcode[5], funct3 and funct7b5 to alu_control (combinational).

Verification
REQ-032 add with mem_ready=1: opcode=0110011, funct3=000, funct7b5=0 -> states 0,1,6,8,0; alu_control=000 in EXECR; reg_write only in ALUWB.
REQ-033 lw with mem_ready low 2 cycles in MEMREAD: opcode=0000011 -> MEMREAD lasts 3 cycles; reg_write with result_src=01 exactly once.
REQ-034 sw: opcode=0100011 -> imm_src=01; mem_write=1, adr_src=1 only in MEMWRITE; reg_write never asserted.
REQ-035 beq: zero_flag=1 gives pc_write=1 in BRANCH; zero_flag=0 gives pc_write=0; alu_control=001 in BRANCH.
REQ-036 Illegal opcode 1111111: illegal_instr pulses for one cycle, then FETCH; no write strobes.
REQ-037 rst_n dropped in MEMWRITE with mem_ready=0 -> mem_write falls immediately and state=0.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types and constants for the multicycle RISC-V control unit.
// Optional build macro: MC_CTRL_BRANCH_EXT_EN (bne/blt/bge decode in the top).
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    AluOpAdd   = 2'b00,
    AluOpSub   = 2'b01,
    AluOpFunct = 2'b10
  } aluop_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRtype  = 7'b0110011;
  localparam logic [6:0] OpItype  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  function automatic logic [1:0] imm_sel(input logic [6:0] op);
    case (op)
      OpStore:  imm_sel = 2'b01;
      OpBranch: imm_sel = 2'b10;
      OpJal:    imm_sel = 2'b11;
      default:  imm_sel = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an alu_control code.
module mc_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  aluop_e     aluop,
  input  logic       op5,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluAdd;
    case (aluop)
      AluOpSub: alu_control = AluSub;
      AluOpFunct: begin
        case (funct3)
          // op5 separates R-type sub from I-type addi whose imm[10] aliases funct7b5
          3'b000:  alu_control = (op5 && funct7b5) ? AluSub : AluAdd;
          3'b010:  alu_control = AluSlt;
          3'b110:  alu_control = AluOr;
          3'b111:  alu_control = AluAnd;
          default: alu_control = AluAdd;
        endcase
      end
      default: alu_control = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RV32 datapath.
// Define MC_CTRL_BRANCH_EXT_EN to add bne/blt/bge to the branch decision.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero_flag,
  input  logic       sign_flag,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       illegal_instr
);

  state_e state_q, state_d;
  logic   run_q;       // low until the first edge after reset; keeps strobes quiet
  logic   is_store_q;  // load/store choice captured in DECODE
  logic   legal_op;
  logic   taken;
  aluop_e aluop;

  always_comb begin
    legal_op = (opcode == OpLoad) || (opcode == OpStore) || (opcode == OpRtype) ||
               (opcode == OpItype) || (opcode == OpBranch) || (opcode == OpJal);
  end

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero_flag;
`ifdef MC_CTRL_BRANCH_EXT_EN
      3'b001:  taken = !zero_flag;
      3'b100:  taken = sign_flag;
      3'b101:  taken = !sign_flag;
`endif
      default: taken = 1'b0;
    endcase
  end

`ifndef MC_CTRL_BRANCH_EXT_EN
  logic unused_sign;
  assign unused_sign = sign_flag;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready && run_q) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRtype:         state_d = StExecR;
          OpItype:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = is_store_q ? StMemWrite : StMemRead;
      StMemRead:  if (mem_ready) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready) state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJal:      state_d = StAluWb;
      default:    state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      run_q      <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (state_q == StDecode) is_store_q <= (opcode == OpStore);
    end
  end

  // Strobes are gated by run_q so an async reset kills them in the same instant.
  always_comb begin
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    adr_src       = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    aluop         = AluOpAdd;
    unique case (state_q)
      StFetch: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready && run_q;
        pc_write   = mem_ready && run_q;
      end
      StDecode: begin
        alu_src_a     = 2'b01;
        alu_src_b     = 2'b01;
        illegal_instr = !legal_op && run_q;
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      StMemRead:  adr_src = 1'b1;
      StMemWb: begin
        result_src = 2'b01;
        reg_write  = run_q;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = run_q;
      end
      StExecR: begin
        alu_src_a = 2'b10;
        aluop     = AluOpFunct;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        aluop     = AluOpFunct;
      end
      StAluWb:    reg_write = run_q;
      StBranch: begin
        alu_src_a = 2'b10;
        aluop     = AluOpSub;
        pc_write  = taken && run_q;
      end
      StJal: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = run_q;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .op5         (opcode[5]),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

  assign imm_src = imm_sel(opcode);
  assign state   = state_q;

endmodule
